// File: rtl/wb_pkg.sv
// Shared write-back definitions: datapath width, register address width and
// the WB result-select encodings used by the pipeline's write-back stage.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Selects which result the WB stage forwards to the register file.
    typedef enum logic [1:0] {
        MEM_TO_REG_ALU = 2'b00,
        MEM_TO_REG_MEM = 2'b01,
        MEM_TO_REG_PC4 = 2'b10
    } mem_to_reg_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO for MDU results. Besides the usual head/full/empty/
// count it exposes the rd field and valid bit of every slot so the owner can
// run a register busy compare against all buffered entries.
module sync_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = REG_ADDR_W + 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic                               pop,
    input  logic [WIDTH-1:0]                   wdata,
    output logic [WIDTH-1:0]                   head,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(DEPTH):0]             count,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]   ent_rd,
    output logic [DEPTH-1:0]                   ent_valid
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    off;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is refused even when a pop frees a slot this cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        off       = '0;
        ent_valid = '0;
        ent_rd    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = AW'(i) - rd_ptr;
            ent_valid[i] = ({1'b0, off} < count);
            ent_rd[i]    = mem[i][WIDTH-1 -: REG_ADDR_W];
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single register-file write port between the pipeline WB
// stage (always wins) and buffered MDU results. An age counter on the FIFO
// head raises stall_req so the pipeline drains a bubble for the MDU.
//
// Handshake: an MDU result transfers on a rising edge where mdu_valid and
// mdu_ready are both high; mdu_ready depends only on registered state
// (FIFO not full), and the MDU must hold mdu_rd/mdu_data stable while
// mdu_valid is high and mdu_ready is low.
module rf_wport_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]       mdu_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  stall_req,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    localparam int ENT_W = REG_ADDR_W + XLEN;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] AGE_LIMIT = 4'(STARVE_LIMIT);

    logic                                  wb_eff;
    logic                                  push;
    logic                                  pop;
    logic [ENT_W-1:0]                      head;
    logic                                  full;
    logic                                  empty;
    logic [CW-1:0]                         count;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
    logic [FIFO_DEPTH-1:0]                 ent_valid;
    logic [3:0]                            age;

    // Writes to x0 are not real writes and leave the port free for the MDU.
    assign wb_eff    = wb_reg_write && (wb_rd != '0);
    assign mdu_ready = !full;
    // Results targeting x0 are accepted and dropped on the floor.
    assign push      = mdu_valid && mdu_ready && (mdu_rd != '0);
    assign pop       = !wb_eff && !empty;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wdata     ({mdu_rd, mdu_data}),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .ent_rd    (ent_rd),
        .ent_valid (ent_valid)
    );

    // Write-port mux: pipeline first, then FIFO head, otherwise idle zeros.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (wb_eff) begin
            rf_we    = 1'b1;
            rf_waddr = wb_rd;
            rf_wdata = wb_data;
        end else if (!empty) begin
            rf_we    = 1'b1;
            rf_waddr = head[ENT_W-1 -: REG_ADDR_W];
            rf_wdata = head[XLEN-1:0];
        end
    end

    // Count cycles the head spends blocked by pipeline writes, saturating.
    always_ff @(posedge clk) begin
        if (rst || empty || pop) begin
            age <= '0;
        end else if (wb_eff && (age != AGE_LIMIT)) begin
            age <= age + 4'd1;
        end
    end

    // Registered-state only, so no input reaches stall_req combinationally.
    assign stall_req = (count != '0) && (age == AGE_LIMIT);

    // Flag ID sources that a buffered MDU result will still overwrite.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] == id_rs1) && (id_rs1 != '0)) rs1_busy = 1'b1;
            if (ent_valid[i] && (ent_rd[i] == id_rs2) && (id_rs2 != '0)) rs2_busy = 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Randomized and directed bench for rf_wport_arbiter with a queue-based
// reference model of the write port, MDU buffer and starvation counter.
module tb_rf_wport_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic            clk;
    logic            rst;
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            mdu_valid;
    logic            mdu_ready;
    logic [4:0]      mdu_rd;
    logic [XLEN-1:0] mdu_data;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            stall_req;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            rs1_busy;
    logic            rs2_busy;

    rf_wport_arbiter #(
        .XLEN         (XLEN),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .mdu_valid    (mdu_valid),
        .mdu_ready    (mdu_ready),
        .mdu_rd       (mdu_rd),
        .mdu_data     (mdu_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .stall_req    (stall_req),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: buffered MDU results {rd, data} in arrival order
    logic [36:0] exp_q[$];
    int          m_age;

    // last observed outputs, for directed checks against fixed values
    logic            o_we, o_ready, o_stall, o_b1, o_b2;
    logic [4:0]      o_waddr;
    logic [XLEN-1:0] o_wdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_age = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0; id_rs1 = '0; id_rs2 = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle: drive at negedge, compare mid-cycle, then advance the model
    // to the state it holds after the next rising edge.
    task automatic step(input logic wre, input logic [4:0] wrd, input logic [XLEN-1:0] wdat,
                        input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] mdat,
                        input logic [4:0] r1, input logic [4:0] r2);
        bit wb_real, m_empty, m_ready, m_pop, m_push, e_we, e_b1, e_b2, e_stall;
        logic [4:0]      e_addr;
        logic [XLEN-1:0] e_data;
        @(negedge clk);
        wb_reg_write = wre; wb_rd = wrd; wb_data = wdat;
        mdu_valid = mv; mdu_rd = mrd; mdu_data = mdat;
        id_rs1 = r1; id_rs2 = r2;
        #1;
        wb_real = wre && (wrd != 0);
        m_empty = (exp_q.size() == 0);
        m_ready = (exp_q.size() < DEPTH);
        if (wb_real) begin
            e_we = 1; e_addr = wrd; e_data = wdat;
        end else if (!m_empty) begin
            e_we = 1; e_addr = exp_q[0][36:32]; e_data = exp_q[0][31:0];
        end else begin
            e_we = 0; e_addr = 0; e_data = 0;
        end
        e_stall = !m_empty && (m_age == LIMIT);
        e_b1 = 0; e_b2 = 0;
        foreach (exp_q[i]) begin
            if (r1 != 0 && exp_q[i][36:32] == r1) e_b1 = 1;
            if (r2 != 0 && exp_q[i][36:32] == r2) e_b2 = 1;
        end
        check("rf_we", 64'(rf_we), 64'(e_we));
        check("rf_waddr", 64'(rf_waddr), 64'(e_addr));
        check("rf_wdata", 64'(rf_wdata), 64'(e_data));
        check("mdu_ready", 64'(mdu_ready), 64'(m_ready));
        check("stall_req", 64'(stall_req), 64'(e_stall));
        check("rs1_busy", 64'(rs1_busy), 64'(e_b1));
        check("rs2_busy", 64'(rs2_busy), 64'(e_b2));
        o_we = rf_we; o_waddr = rf_waddr; o_wdata = rf_wdata;
        o_ready = mdu_ready; o_stall = stall_req; o_b1 = rs1_busy; o_b2 = rs2_busy;
        // state update
        m_pop  = !wb_real && !m_empty;
        m_push = mv && m_ready && (mrd != 0);
        if (m_pop || m_empty) m_age = 0;
        else if (wb_real && m_age < LIMIT) m_age = m_age + 1;
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) exp_q.push_back({mrd, mdat});
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        do_reset();

        // reset / idle
        idle();
        check("reset_we", 64'(o_we), 64'd0);
        check("reset_ready", 64'(o_ready), 64'd1);
        check("reset_stall", 64'(o_stall), 64'd0);

        // pipeline write, zero latency
        step(1, 5, 32'h11, 0, 0, 0, 0, 0);
        check("wb_we", 64'(o_we), 64'd1);
        check("wb_waddr", 64'(o_waddr), 64'd5);
        check("wb_wdata", 64'(o_wdata), 64'h11);

        // MDU push then drain on the next cycle
        step(0, 0, 0, 1, 7, 32'hAB, 0, 0);
        check("push_no_bypass", 64'(o_we), 64'd0);
        idle();
        check("mdu_waddr", 64'(o_waddr), 64'd7);
        check("mdu_wdata", 64'(o_wdata), 64'hAB);
        idle();
        check("mdu_drained", 64'(o_we), 64'd0);

        // starvation: head blocked by pipeline writes
        step(1, 1, 32'h1, 1, 3, 32'h33, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 32'h1, 0, 0, 0, 3, 4);
            check("starve_busy", 64'(o_b1), 64'd1);
            check("starve_nostall", 64'(o_stall), 64'd0);
        end
        step(0, 0, 0, 0, 0, 0, 3, 0);
        check("starve_stall", 64'(o_stall), 64'd1);
        check("bubble_waddr", 64'(o_waddr), 64'd3);
        step(1, 2, 32'h2, 0, 0, 0, 3, 0);
        check("stall_drop", 64'(o_stall), 64'd0);
        check("busy_clear", 64'(o_b1), 64'd0);

        // fill while blocked, third result held, FIFO pop order
        step(1, 1, 32'h1, 1, 9, 32'h99, 0, 0);
        step(1, 1, 32'h1, 1, 10, 32'hAA, 0, 0);
        step(1, 1, 32'h1, 1, 11, 32'hBB, 9, 10);
        check("full_ready", 64'(o_ready), 64'd0);
        check("full_busy2", 64'(o_b2), 64'd1);
        step(0, 0, 0, 1, 11, 32'hBB, 0, 0);
        check("order_first", 64'(o_waddr), 64'd9);
        check("still_full", 64'(o_ready), 64'd0);
        step(0, 0, 0, 1, 11, 32'hBB, 0, 0);
        check("order_second", 64'(o_waddr), 64'd10);
        check("ready_again", 64'(o_ready), 64'd1);
        idle();
        check("order_third", 64'(o_waddr), 64'd11);
        idle();

        // rd=0 result dropped; wb write to x0 yields the port
        step(0, 0, 0, 1, 0, 32'hDEAD, 0, 0);
        check("rd0_ready", 64'(o_ready), 64'd1);
        idle();
        check("rd0_never_written", 64'(o_we), 64'd0);
        step(0, 0, 0, 1, 12, 32'hC0, 0, 0);
        step(1, 0, 32'hFFFF, 0, 0, 0, 0, 0);
        check("x0_yield_addr", 64'(o_waddr), 64'd12);
        check("x0_yield_data", 64'(o_wdata), 64'hC0);

        // randomized traffic with occasional mid-run reset
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] r1, r2, mrd;
            if ($urandom_range(0, 499) == 0) do_reset();
            mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r1  = 5'($urandom_range(0, 31));
            r2  = 5'($urandom_range(0, 31));
            if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) r1 = exp_q[0][36:32];
            step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 2) == 0), mrd, $urandom, r1, r2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
